// File: rtl/tft_draw_arbiter.sv
// tft_draw_arbiter: power-up/init sequencer and round-robin arbiter owning the tft_ctrl draw port.
module tft_draw_arbiter #(
  parameter int NREQ = 3,
  parameter int DLY_WIDTH = 16
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              soft_init,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*80-1:0] cmd_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   cnext_out,
  output logic              ready,
  output logic              tft_init,
  output logic              tft_draw,
  output logic [79:0]       tft_cmd,
  input  logic              tft_busy,
  input  logic              tft_done,
  input  logic              tft_cnext
);
  localparam int GW = $clog2(NREQ);
  typedef enum logic [2:0] {PWRDLY, INIT, IDLE, ISSUE, GAP} state_t;
  state_t state, state_n;
  logic [DLY_WIDTH-1:0] cnt, cnt_n;
  logic [GW-1:0] rr, rr_n, grant, grant_n, pick;
  logic found;
  logic [NREQ-1:0] ack_n;
  logic ready_n, init_n, draw_n;
  logic [63:0] geom, geom_n;
  logic [15:0] color_q, color_n, live_color;
  assign live_color = cmd_in[80*grant+64 +: 16];
  assign tft_cmd = {state == ISSUE ? live_color : color_q, geom};
  assign cnext_out = (state == ISSUE && tft_cnext) ? NREQ'(1) << grant : '0;
  // first requesting index after the last grant, wrapping
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!found && req[(int'(rr) + 1 + i) % NREQ]) begin
        found = 1'b1;
        pick = GW'((int'(rr) + 1 + i) % NREQ);
      end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rr_n = rr;
    grant_n = grant;
    ack_n = '0;
    ready_n = ready;
    init_n = 1'b0;
    draw_n = tft_draw;
    geom_n = geom;
    color_n = state == ISSUE ? live_color : color_q;
    case (state)
      PWRDLY: begin
        cnt_n = cnt + 1'b1;
        if (&cnt) begin
          init_n = 1'b1;
          state_n = INIT;
        end
      end
      // a done coincident with our own init pulse belongs to something earlier
      INIT: if (tft_done && !tft_init) begin
        ready_n = 1'b1;
        state_n = IDLE;
      end
      IDLE: if (soft_init) begin
        ready_n = 1'b0;
        init_n = 1'b1;
        state_n = INIT;
      end else if (!tft_busy && found) begin
        grant_n = pick;
        rr_n = pick;
        geom_n = cmd_in[80*pick +: 64];
        color_n = cmd_in[80*pick+64 +: 16];
        draw_n = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: if (tft_done) begin
        draw_n = 1'b0;
        ack_n[grant] = 1'b1;
        state_n = GAP;
      end
      GAP: state_n = IDLE;
      default: state_n = PWRDLY;
    endcase
  end
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      state <= PWRDLY;
      cnt <= '0;
      rr <= GW'(NREQ - 1);
      grant <= '0;
      ack <= '0;
      ready <= 1'b0;
      tft_init <= 1'b0;
      tft_draw <= 1'b0;
      geom <= '0;
      color_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rr <= rr_n;
      grant <= grant_n;
      ack <= ack_n;
      ready <= ready_n;
      tft_init <= init_n;
      tft_draw <= draw_n;
      geom <= geom_n;
      color_q <= color_n;
    end
endmodule
